serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor. It sums two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It is the sequential, width-generalised successor of the combinational half adder and adds subtract mode, a start/busy/done handshake and signed overflow detection. It is intended for area-constrained datapaths where latency of WIDTH+1 cycles is acceptable.

---
 rtl/serial_adder.sv | 144 ++++++++++++++
 tb/tb_serial_adder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process the
// operands LSB first; result, carry and signed overflow are registered at the last step.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             OVERFLOW
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             s_bit;
    logic             c_nxt;
    logic             acc_en;
    logic [WIDTH-1:0] acc_shift;

    assign s_bit  = ra_q[0] ^ rb_q[0] ^ c_q;
    assign c_nxt  = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
    assign acc_en = (state_q == S_RUN);

    // acc_shift is the result so far with the current bit placed at the MSB;
    // only WIDTH-1 earlier bits need storing since the last bit goes straight to SUM.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_shift = s_bit;
        end else begin : g_acc_wn
            logic [WIDTH-2:0] racc_q;
            logic [WIDTH-2:0] racc_d;

            assign acc_shift = {s_bit, racc_q};
            assign racc_d    = acc_shift[WIDTH-1:1];

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    racc_q <= '0;
                end else if (acc_en) begin
                    racc_q <= racc_d;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    ra_d    = A;
                    rb_d    = SUB ? ~B : B;
                    c_d     = SUB;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                c_d   = c_nxt;
                cnt_d = cnt_q + CW'(1);
                // c_q here is the carry into the MSB, so c_q ^ c_nxt is signed overflow.
                if (cnt_q == LAST) begin
                    sum_d   = acc_shift;
                    carry_d = c_nxt;
                    ovf_d   = c_q ^ c_nxt;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (START) begin
                    ra_d    = A;
                    rb_d    = SUB ? ~B : B;
                    c_d     = SUB;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign BUSY     = (state_q == S_RUN);
    assign DONE     = (state_q == S_FIN);
    assign SUM      = sum_q;
    assign CARRY    = carry_q;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 1-bit instance checked against an
// arithmetic reference model with directed, handshake, reset and random cases.
module tb_serial_adder;

    logic       CLK;
    logic       RST_N;

    logic       START;
    logic       SUB;
    logic [7:0] A;
    logic [7:0] B;
    logic       BUSY;
    logic       DONE;
    logic [7:0] SUM;
    logic       CARRY;
    logic       OVERFLOW;

    logic       START1;
    logic       SUB1;
    logic [0:0] A1;
    logic [0:0] B1;
    logic       BUSY1;
    logic       DONE1;
    logic [0:0] SUM1;
    logic       CARRY1;
    logic       OVERFLOW1;

    int checks;
    int errors;

    logic [7:0] prev_sum;
    logic       prev_carry;
    logic       prev_ovf;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .SUB      (SUB),
        .A        (A),
        .B        (B),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .SUM      (SUM),
        .CARRY    (CARRY),
        .OVERFLOW (OVERFLOW)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START1),
        .SUB      (SUB1),
        .A        (A1),
        .B        (B1),
        .BUSY     (BUSY1),
        .DONE     (DONE1),
        .SUM      (SUM1),
        .CARRY    (CARRY1),
        .OVERFLOW (OVERFLOW1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                   output logic [7:0] s, output logic c, output logic v);
        int ua;
        int ub;
        int sa;
        int sb;
        int r;
        int sr;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            r  = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            r  = ua + ub;
            sr = sa + sb;
            c  = (r > 255);
        end
        s = r[7:0];
        v = (sr > 127) || (sr < -128);
    endfunction

    // Caller is positioned just after a rising edge. When chained=1 the start
    // edge has already happened (back-to-back from FIN).
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input bit glitch, input bit chained,
                       input bit chain_next, input logic [7:0] na, input logic [7:0] nb,
                       input logic nsub);
        logic [7:0] es;
        logic       ec;
        logic       ev;
        model8(a, b, sub, es, ec, ev);
        if (!chained) begin
            START = 1'b1;
            A     = a;
            B     = b;
            SUB   = sub;
            @(posedge CLK);
            #1;
        end
        for (int i = 0; i < 8; i++) begin
            chk("busy_run", BUSY, 1'b1);
            chk("done_run", DONE, 1'b0);
            chk("sum_hold", SUM, prev_sum);
            chk("carry_hold", CARRY, prev_carry);
            START = (glitch && i == 3) ? 1'b1 : 1'b0;
            A     = 8'($urandom);
            B     = 8'($urandom);
            SUB   = 1'($urandom);
            @(posedge CLK);
            #1;
        end
        chk("done_pulse", DONE, 1'b1);
        chk("busy_fin", BUSY, 1'b0);
        chk("sum", SUM, es);
        chk("carry", CARRY, ec);
        chk("overflow", OVERFLOW, ev);
        prev_sum   = es;
        prev_carry = ec;
        prev_ovf   = ev;
        if (chain_next) begin
            START = 1'b1;
            A     = na;
            B     = nb;
            SUB   = nsub;
            @(posedge CLK);
            #1;
            START = 1'b0;
        end else begin
            START = 1'b0;
            @(posedge CLK);
            #1;
            chk("done_once", DONE, 1'b0);
            chk("idle_busy", BUSY, 1'b0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        prev_sum   = 8'h00;
        prev_carry = 1'b0;
        prev_ovf   = 1'b0;
        RST_N  = 1'b0;
        START  = 1'b0;
        SUB    = 1'b0;
        A      = 8'h00;
        B      = 8'h00;
        START1 = 1'b0;
        SUB1   = 1'b0;
        A1     = 1'b0;
        B1     = 1'b0;

        #3;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_sum", SUM, 8'h00);
        chk("rst_carry", CARRY, 1'b0);
        chk("rst_ovf", OVERFLOW, 1'b0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Directed arithmetic cases
        op8(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        op8(8'd5, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        op8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

        // START during BUSY is ignored
        op8(8'd10, 8'd20, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

        // Back-to-back through FIN
        op8(8'd50, 8'd60, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2, 1'b0);
        op8(8'd1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        chk("b2b_sum3", SUM, 8'd3);

        // Width-1 half-adder behaviour
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            logic [1:0] exp1;
            ab     = 2'(i);
            START1 = 1'b1;
            SUB1   = 1'b0;
            A1     = ab[1];
            B1     = ab[0];
            exp1   = 2'(ab[1]) + 2'(ab[0]);
            @(posedge CLK);
            #1;
            START1 = 1'b0;
            chk("w1_busy", BUSY1, 1'b1);
            chk("w1_done_early", DONE1, 1'b0);
            @(posedge CLK);
            #1;
            chk("w1_done", DONE1, 1'b1);
            chk("w1_busy_fin", BUSY1, 1'b0);
            chk("w1_sum", SUM1, exp1[0]);
            chk("w1_carry", CARRY1, exp1[1]);
            @(posedge CLK);
            #1;
            chk("w1_done_once", DONE1, 1'b0);
        end

        // Reset in the middle of an operation after a nonzero result
        op8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        START = 1'b1;
        A     = 8'h33;
        B     = 8'h44;
        SUB   = 1'b0;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_busy", BUSY, 1'b0);
        chk("mid_rst_done", DONE, 1'b0);
        chk("mid_rst_sum", SUM, 8'h00);
        chk("mid_rst_carry", CARRY, 1'b0);
        chk("mid_rst_ovf", OVERFLOW, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N      = 1'b1;
        prev_sum   = 8'h00;
        prev_carry = 1'b0;
        prev_ovf   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            chk("post_rst_no_done", DONE, 1'b0);
        end
        op8(8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

        // Randomized operations, some with ignored START pulses and chaining
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            op8(ra, rb, rs, 1'($urandom), 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
